mig_ui_master: RTL and testbench

MIG_UI_MASTER -- requirements
Module: mig_ui_master

---
 rtl/mig_ui_master.sv | 166 ++++++++++++++++
 tb/tb_mig_ui_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_ui_master.sv
// User-side master for a MIG-style UI port: turns single read/write requests
// into command/write-data transactions and tracks outstanding read returns.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a new request (calibrated, read budget available)
// WR    | write command and/or write data still waiting for acceptance
// RD    | read command waiting for acceptance
module mig_ui_master #(
    parameter int MAX_OUT = 8
) (
    input  logic         ui_clk,
    input  logic         ui_rst_n,
    input  logic         init_calib_complete,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [29:0]  req_addr,
    input  logic [255:0] req_wdata,
    input  logic [31:0]  req_wmask,
    output logic         rsp_valid,
    output logic [255:0] rsp_data,
    output logic [29:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [255:0] app_wdf_data,
    output logic [31:0]  app_wdf_mask,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    input  logic [255:0] app_rd_data,
    input  logic         app_rd_data_valid,
    input  logic         app_rd_data_end,
    output logic         app_sr_req,
    output logic         app_ref_req,
    output logic         app_zq_req,
    output logic [3:0]   outstanding,
    output logic         err_unexp
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);
    localparam logic [2:0] CMD_WR    = 3'b000;
    localparam logic [2:0] CMD_RD    = 3'b001;

    state_t         state, state_n;
    logic           en_n, wren_n, end_n, rsp_valid_n, err_n;
    logic [2:0]     cmd_n;
    logic [29:0]    addr_n;
    logic [255:0]   wdata_n, rsp_data_n;
    logic [31:0]    wmask_n;
    logic [3:0]     cnt_n;
    logic           accept, cmd_acc, dat_acc, rd_issue;

    // One beat per burst, so the end-of-burst flag carries no information.
    logic unused_rd_end;
    assign unused_rd_end = app_rd_data_end;

    assign app_sr_req  = 1'b0;
    assign app_ref_req = 1'b0;
    assign app_zq_req  = 1'b0;

    // Held low during reset so nothing is offered while the block is cleared.
    assign req_ready = ui_rst_n && (state == S_IDLE) && init_calib_complete
                       && (outstanding < MAX_OUT_L);
    assign accept    = req_valid && req_ready;
    assign cmd_acc   = app_en && app_rdy;
    assign dat_acc   = app_wdf_wren && app_wdf_rdy;

    // Next state, next registered outputs and outstanding-read bookkeeping.
    always_comb begin
        state_n     = state;
        en_n        = app_en;
        cmd_n       = app_cmd;
        addr_n      = app_addr;
        wdata_n     = app_wdf_data;
        wmask_n     = app_wdf_mask;
        wren_n      = app_wdf_wren;
        end_n       = app_wdf_end;
        rd_issue    = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    en_n   = 1'b1;
                    addr_n = req_addr;
                    if (req_we) begin
                        state_n = S_WR;
                        cmd_n   = CMD_WR;
                        wdata_n = req_wdata;
                        wmask_n = req_wmask;
                        wren_n  = 1'b1;
                        end_n   = 1'b1;
                    end else begin
                        state_n = S_RD;
                        cmd_n   = CMD_RD;
                    end
                end
            end
            S_WR: begin
                // Command and data channels retire independently.
                if (cmd_acc) en_n = 1'b0;
                if (dat_acc) begin
                    wren_n = 1'b0;
                    end_n  = 1'b0;
                end
                if ((!app_en || cmd_acc) && (!app_wdf_wren || dat_acc))
                    state_n = S_IDLE;
            end
            S_RD: begin
                if (cmd_acc) begin
                    en_n     = 1'b0;
                    rd_issue = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Issue and return in the same cycle cancel out; a stray return
        // never drives the count below zero.
        cnt_n = outstanding;
        if (rd_issue && !app_rd_data_valid)
            cnt_n = outstanding + 4'd1;
        else if (!rd_issue && app_rd_data_valid && (outstanding != 4'd0))
            cnt_n = outstanding - 4'd1;

        err_n       = err_unexp || (app_rd_data_valid && (outstanding == 4'd0));
        rsp_valid_n = app_rd_data_valid;
        rsp_data_n  = app_rd_data_valid ? app_rd_data : rsp_data;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ui_clk) begin
        if (!ui_rst_n) begin
            state        <= S_IDLE;
            app_en       <= 1'b0;
            app_cmd      <= 3'b000;
            app_addr     <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            outstanding  <= 4'd0;
            err_unexp    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
        end else begin
            state        <= state_n;
            app_en       <= en_n;
            app_cmd      <= cmd_n;
            app_addr     <= addr_n;
            app_wdf_data <= wdata_n;
            app_wdf_mask <= wmask_n;
            app_wdf_wren <= wren_n;
            app_wdf_end  <= end_n;
            outstanding  <= cnt_n;
            err_unexp    <= err_n;
            rsp_valid    <= rsp_valid_n;
            rsp_data     <= rsp_data_n;
        end
    end

endmodule

// File: tb/tb_mig_ui_master.sv
// Bench for mig_ui_master: random traffic plus directed scenarios, checked
// every cycle against a transaction-level model of pending channels and
// outstanding-read count.
module tb_mig_ui_master;

    localparam int TB_MAX = 2;

    logic         ui_clk = 1'b0;
    logic         ui_rst_n;
    logic         init_calib_complete;
    logic         req_valid, req_ready, req_we;
    logic [29:0]  req_addr;
    logic [255:0] req_wdata;
    logic [31:0]  req_wmask;
    logic         rsp_valid;
    logic [255:0] rsp_data;
    logic [29:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [255:0] app_wdf_data;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [255:0] app_rd_data;
    logic         app_rd_data_valid, app_rd_data_end;
    logic         app_sr_req, app_ref_req, app_zq_req;
    logic [3:0]   outstanding;
    logic         err_unexp;

    mig_ui_master #(.MAX_OUT(TB_MAX)) dut (
        .ui_clk(ui_clk), .ui_rst_n(ui_rst_n),
        .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end),
        .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
        .outstanding(outstanding), .err_unexp(err_unexp)
    );

    always #5 ui_clk = ~ui_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: which channels still owe a handshake, and the count of
    // reads sent to the controller but not yet answered.
    bit           m_pend_cmd, m_pend_dat, m_err, m_rsp_valid;
    logic [2:0]   m_cmd;
    logic [29:0]  m_addr;
    logic [255:0] m_wdata, m_rsp_data;
    logic [31:0]  m_wmask;
    int           m_cnt;

    // Read responder (stimulus side).
    int rd_due[$];
    bit hold_ret = 1'b0;
    bit inj_ret  = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_clear();
        m_pend_cmd = 0; m_pend_dat = 0; m_err = 0; m_rsp_valid = 0;
        m_cmd = 3'b000; m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_rsp_data = '0; m_cnt = 0;
    endtask

    // One clock: drive responder, check req_ready, advance model, check outputs.
    task automatic step();
        bit m_ready, acc, issue, ret;
        app_rd_data_valid = 1'b0;
        if (inj_ret) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = rand256();
        end else if (!hold_ret && rd_due.size() > 0 && rd_due[0] <= cyc) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = rand256();
            void'(rd_due.pop_front());
        end
        app_rd_data_end = app_rd_data_valid;
        #1;
        m_ready = ui_rst_n && !m_pend_cmd && !m_pend_dat && init_calib_complete
                  && (m_cnt < TB_MAX);
        chk("req_ready", {255'd0, req_ready}, {255'd0, m_ready});
        acc   = req_valid && m_ready;
        issue = m_pend_cmd && (m_cmd == 3'b001) && app_rdy;
        ret   = app_rd_data_valid;
        if (ui_rst_n && issue) rd_due.push_back(cyc + int'($urandom_range(1, 4)));
        @(posedge ui_clk);
        cyc++;
        if (!ui_rst_n) begin
            model_clear();
        end else begin
            if (m_pend_cmd && app_rdy)     m_pend_cmd = 0;
            if (m_pend_dat && app_wdf_rdy) m_pend_dat = 0;
            if (acc) begin
                m_pend_cmd = 1;
                m_pend_dat = req_we;
                m_cmd      = req_we ? 3'b000 : 3'b001;
                m_addr     = req_addr;
                if (req_we) begin
                    m_wdata = req_wdata;
                    m_wmask = req_wmask;
                end
            end
            if (ret && m_cnt == 0) m_err = 1;
            if (issue && !ret)                  m_cnt = m_cnt + 1;
            else if (!issue && ret && m_cnt > 0) m_cnt = m_cnt - 1;
            m_rsp_valid = ret;
            if (ret) m_rsp_data = app_rd_data;
        end
        #1;
        chk("app_en",   {255'd0, app_en},       {255'd0, m_pend_cmd});
        chk("wren",     {255'd0, app_wdf_wren}, {255'd0, m_pend_dat});
        chk("wdf_end",  {255'd0, app_wdf_end},  {255'd0, m_pend_dat});
        chk("app_cmd",  {253'd0, app_cmd},      {253'd0, m_cmd});
        chk("app_addr", {226'd0, app_addr},     {226'd0, m_addr});
        chk("wdf_data", app_wdf_data,           m_wdata);
        chk("wdf_mask", {224'd0, app_wdf_mask}, {224'd0, m_wmask});
        chk("outstanding", {252'd0, outstanding}, 256'(m_cnt));
        chk("err_unexp", {255'd0, err_unexp},   {255'd0, m_err});
        chk("rsp_valid", {255'd0, rsp_valid},   {255'd0, m_rsp_valid});
        chk("rsp_data",  rsp_data,              m_rsp_data);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        app_rdy = 1; app_wdf_rdy = 1; init_calib_complete = 1;
        hold_ret = 0; inj_ret = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rd_due.delete();
        ui_rst_n = 0;
        step();
        step();
        ui_rst_n = 1;
    endtask

    initial begin
        model_clear();
        ui_rst_n = 0;
        idle_inputs();
        app_rd_data = '0; app_rd_data_valid = 0; app_rd_data_end = 0;
        @(posedge ui_clk); #1;
        do_reset();
        chk("rst_outstanding", {252'd0, outstanding}, 256'd0);
        chk("tie_sr",  {255'd0, app_sr_req},  256'd0);
        chk("tie_ref", {255'd0, app_ref_req}, 256'd0);
        chk("tie_zq",  {255'd0, app_zq_req},  256'd0);

        // Simple write, all ready.
        req_valid = 1; req_we = 1; req_addr = 30'h10; req_wdata = 256'h1234; req_wmask = '0;
        step();
        chk("w1_en", {255'd0, app_en}, 256'd1);
        chk("w1_addr", {226'd0, app_addr}, 256'h10);
        req_valid = 0;
        step();
        chk("w1_en_drop", {255'd0, app_en}, 256'd0);
        step();
        chk("w1_ready_back", {255'd0, req_ready}, 256'd1);

        // Write with command stalled three cycles, data accepted at once.
        req_valid = 1; req_we = 1; req_addr = 30'h2A5; req_wdata = rand256(); app_rdy = 0;
        step();
        req_valid = 0;
        step();
        chk("w2_wren_pulse", {255'd0, app_wdf_wren}, 256'd0);
        step(); step();
        chk("w2_en_held", {255'd0, app_en}, 256'd1);
        chk("w2_addr_stable", {226'd0, app_addr}, 256'h2A5);
        app_rdy = 1;
        step();
        chk("w2_en_done", {255'd0, app_en}, 256'd0);

        // Single read returning data.
        req_valid = 1; req_we = 0; req_addr = 30'h10;
        step();
        req_valid = 0;
        step();
        chk("r1_out1", {252'd0, outstanding}, 256'd1);
        for (int i = 0; i < 6; i++) step();
        chk("r1_out0", {252'd0, outstanding}, 256'd0);

        // Read budget exhausted, then released by one return.
        hold_ret = 1; req_valid = 1; req_we = 0;
        for (int i = 0; i < 6; i++) begin
            req_addr = 30'($urandom);
            step();
        end
        chk("lim_out2", {252'd0, outstanding}, 256'd2);
        chk("lim_ready", {255'd0, req_ready}, 256'd0);
        hold_ret = 0;
        for (int i = 0; i < 4; i++) step();
        req_valid = 0;
        for (int i = 0; i < 10; i++) step();

        // Unexpected read data.
        do_reset();
        inj_ret = 1;
        step();
        inj_ret = 0;
        chk("unexp_err", {255'd0, err_unexp}, 256'd1);
        step(); step();
        chk("unexp_sticky", {255'd0, err_unexp}, 256'd1);
        chk("unexp_out0", {252'd0, outstanding}, 256'd0);

        // Reset while a command is stalled.
        do_reset();
        req_valid = 1; req_we = 1; req_addr = 30'h77; app_rdy = 0;
        step();
        req_valid = 0;
        step();
        ui_rst_n = 0;
        step();
        ui_rst_n = 1;
        chk("rst_mid_en", {255'd0, app_en}, 256'd0);
        chk("rst_mid_out", {252'd0, outstanding}, 256'd0);

        // Random traffic including occasional resets and calibration loss.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_valid           = ($urandom_range(0, 2) != 0);
            req_we              = $urandom_range(0, 1) == 1;
            req_addr            = 30'($urandom);
            req_wdata           = rand256();
            req_wmask           = $urandom;
            app_rdy             = ($urandom_range(0, 9) < 7);
            app_wdf_rdy         = ($urandom_range(0, 9) < 7);
            init_calib_complete = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) hold_ret = ~hold_ret;
            ui_rst_n            = ($urandom_range(0, 299) != 0);
            step();
        end
        ui_rst_n = 1;
        idle_inputs();
        for (int i = 0; i < 10; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
